commit_ring_ctrl: RTL and testbench
===================================

Name: commit_ring_ctrl

Overview:
Owns the NCOMMIT-entry circular commit buffer that feeds the alu scheduler. It allocates up to 4 commit slots per cycle to the rename/decode stage and retires completed entries in order. It rolls the tail back on a branch-mispredict flush. Each cycle it publishes the head pointer plus absolute and head-rotated live-entry masks; the scheduler uses these to drive its rotator and ready logic.

Parameters:
NCOMMIT, 32, number of commit slots (power of 2)
LNCOMMIT, $clog2(NCOMMIT), pointer width
NALLOC, 4, maximum allocations per cycle
NRETIRE, 4, maximum retirements per cycle

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
alloc_count  in  $clog2(NALLOC+1)  slots requested this cycle (0..NALLOC)
alloc_ack  out  1  request granted, all-or-nothing (combinational)
alloc_base  out  LNCOMMIT  first slot index granted (equals tail)
retire_count  in  $clog2(NRETIRE+1)  entries retiring from head this cycle
flush_valid  in  1  squash from flush_index to tail
flush_index  in  LNCOMMIT  first squashed slot
commit_head  out  LNCOMMIT  oldest live slot (scheduler rotate amount)
commit_tail  out  LNCOMMIT  next free slot
commit_valid  out  NCOMMIT  live mask, absolute slot order
commit_valid_rot  out  NCOMMIT  live mask rotated so bit0 = head
free_count  out  LNCOMMIT+1  free slots, 0..NCOMMIT
retire_err  out  1  sticky: retire_count exceeded occupancy

Behaviour:
- State: head, tail (LNCOMMIT bits, wrap mod NCOMMIT); count (LNCOMMIT+1 bits, 0..NCOMMIT). Full: count==NCOMMIT. Empty: count==0. head==tail is ambiguous; count resolves it.
- Reset: head=tail=0, count=0, commit_valid=0, commit_valid_rot=0, free_count=NCOMMIT, retire_err=0, alloc_ack=0.
- alloc_ack = !flush_valid && alloc_count!=0 && alloc_count <= free_count (registered value).
- Slots freed by a same-cycle retire are not usable until the next cycle.
- alloc_base = tail whenever alloc_ack is asserted.
- Each granted slot is alloc_base+k mod NCOMMIT, k=0..alloc_count-1.
- Retire: r = min(retire_count, count). head += r. If retire_count > count, set retire_err (cleared only by reset).
- Alloc: if alloc_ack, tail += alloc_count.
- Next count = count - r + (alloc_ack ? alloc_count : 0).
- Flush (priority over alloc; retire in the same cycle still applies):
  - tail := flush_index.
  - count := (flush_index - head_next) mod NCOMMIT.
  - flush_index==head_next squashes everything, so count becomes 0.
  - flush_index must lie within the live range; outside it is undefined and not checked.
- All state outputs are registered and reflect the updated state one cycle after the event.
- commit_valid[i]=1 iff (i - head) mod NCOMMIT < count.
- commit_valid_rot[j]=1 iff j < count (thermometer code).
- free_count = NCOMMIT - count.
- Wrap: tail crosses NCOMMIT-1 to 0 with no bubble; alloc_base=30 with alloc_count=4 grants slots 30,31,0,1.
- Simultaneous alloc and retire in a full ring: alloc is refused (free_count==0); retire proceeds.
- Reset asserted mid-operation overrides all inputs in that cycle.

Decomposition:
- Shared package: NCOMMIT/LNCOMMIT/NALLOC/NRETIRE defaults, commit_idx_t typedef (LNCOMMIT bits), commit_cnt_t typedef (LNCOMMIT+1 bits).
- Reuse the existing rot module, with r=head, to derive commit_valid from the thermometer mask.
- One sub-module, commit_thermo (count -> NCOMMIT thermometer mask).

Test Plan:
- Reset then alloc_count=4 for 8 cycles -> acks 8 times; alloc_base 0,4,...,28; free_count reaches 0; a 9th request gets ack=0.
- Full ring, retire_count=4 with alloc_count=4 in the same cycle -> no ack that cycle; next cycle head=4, free_count=4, and alloc is acked with base=0.
- Head=28, count=0; alloc 4 then 4 -> bases 28 and 0; commit_valid=0xF000000F; commit_valid_rot=0xFF.
- Head=2, tail=12, flush_valid with flush_index=6 plus alloc_count=3 -> alloc_ack=0; next cycle tail=6, count=4, commit_valid=0x3C.
- Count=2, retire_count=3 -> head advances by 2, count=0, retire_err=1 and stays set until reset.
- Flush with flush_index=head_next while retiring 1 -> count=0, commit_valid=0, free_count=32.

Source files
------------

// File: rtl/commit_ring_ctrl_pkg.sv
// ============================================================================
// commit_ring_ctrl_pkg : shared sizes and index/count types for the commit ring
// Revision: 1.0
// ============================================================================
`default_nettype none

package commit_ring_ctrl_pkg;

    localparam int NCOMMIT  = 32;
    localparam int LNCOMMIT = $clog2(NCOMMIT);
    localparam int NALLOC   = 4;
    localparam int NRETIRE  = 4;
    localparam int ALLOC_W  = $clog2(NALLOC + 1);
    localparam int RETIRE_W = $clog2(NRETIRE + 1);

    typedef logic [LNCOMMIT-1:0] commit_idx_t;
    typedef logic [LNCOMMIT:0]   commit_cnt_t;

endpackage

`default_nettype wire

// File: rtl/commit_ring_ctrl_thermo.sv
// ============================================================================
// commit_thermo : occupancy count to thermometer mask (bit j set iff j < count)
// Revision: 1.0
// ============================================================================
`default_nettype none

module commit_thermo
    import commit_ring_ctrl_pkg::*;
(
    input  logic [LNCOMMIT:0]  count,
    output logic [NCOMMIT-1:0] mask
);

    for (genvar j = 0; j < NCOMMIT; j++) begin : g_bit
        assign mask[j] = (commit_cnt_t'(j) < count);
    end

endmodule

`default_nettype wire

// File: rtl/rot.sv
// ============================================================================
// rot : rotate-left of an N-bit vector by r positions (dout[i] = din[i-r])
// Revision: 1.0
// ============================================================================
`default_nettype none

module rot #(
    parameter int N  = 32,
    parameter int LN = $clog2(N)
) (
    input  logic [N-1:0]  din,
    input  logic [LN-1:0] r,
    output logic [N-1:0]  dout
);

    logic [2*N-1:0] dbl;

    // Shifting the doubled word brings the wrapped bits into the upper half.
    assign dbl  = {din, din} << r;
    assign dout = dbl[2*N-1:N];

endmodule

`default_nettype wire

// File: rtl/commit_ring_ctrl.sv
// ============================================================================
// commit_ring_ctrl : circular commit buffer pointers, in-order retire, flush
//                    rollback and live-entry masks for the alu scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

module commit_ring_ctrl
    import commit_ring_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [ALLOC_W-1:0]  alloc_count,
    output logic                alloc_ack,
    output logic [LNCOMMIT-1:0] alloc_base,
    input  logic [RETIRE_W-1:0] retire_count,
    input  logic                flush_valid,
    input  logic [LNCOMMIT-1:0] flush_index,
    output logic [LNCOMMIT-1:0] commit_head,
    output logic [LNCOMMIT-1:0] commit_tail,
    output logic [NCOMMIT-1:0]  commit_valid,
    output logic [NCOMMIT-1:0]  commit_valid_rot,
    output logic [LNCOMMIT:0]   free_count,
    output logic                retire_err
);

    commit_cnt_t          count;
    commit_cnt_t          retire_amt;
    commit_cnt_t          alloc_amt;
    commit_cnt_t          count_next;
    commit_idx_t          head_next;
    commit_idx_t          tail_next;
    logic                 retire_over;
    logic [NCOMMIT-1:0]   thermo_next;
    logic [NCOMMIT-1:0]   valid_next;

    // Grant uses the registered free count, so same-cycle retires cannot be reused.
    assign alloc_ack  = !flush_valid && (alloc_count != '0) &&
                        (commit_cnt_t'(alloc_count) <= free_count);
    assign alloc_base = commit_tail;

    assign retire_over = commit_cnt_t'(retire_count) > count;
    assign retire_amt  = retire_over ? count : commit_cnt_t'(retire_count);
    assign alloc_amt   = alloc_ack ? commit_cnt_t'(alloc_count) : '0;
    assign head_next   = commit_head + commit_idx_t'(retire_amt);

    always_comb begin
        tail_next  = commit_tail + commit_idx_t'(alloc_amt);
        count_next = count - retire_amt + alloc_amt;
        if (flush_valid) begin
            // Flush rolls tail back; survivors are those between new head and flush point.
            tail_next  = flush_index;
            count_next = commit_cnt_t'(commit_idx_t'(flush_index - head_next));
        end
    end

    commit_thermo u_thermo (
        .count (count_next),
        .mask  (thermo_next)
    );

    rot #(
        .N  (NCOMMIT),
        .LN (LNCOMMIT)
    ) u_rot (
        .din  (thermo_next),
        .r    (head_next),
        .dout (valid_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_head      <= '0;
            commit_tail      <= '0;
            count            <= '0;
            free_count       <= commit_cnt_t'(NCOMMIT);
            commit_valid     <= '0;
            commit_valid_rot <= '0;
            retire_err       <= 1'b0;
        end else begin
            commit_head      <= head_next;
            commit_tail      <= tail_next;
            count            <= count_next;
            free_count       <= commit_cnt_t'(NCOMMIT) - count_next;
            commit_valid     <= valid_next;
            commit_valid_rot <= thermo_next;
            if (retire_over) begin
                retire_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_commit_ring_ctrl.sv
// ============================================================================
// tb_commit_ring_ctrl : directed self-checking bench for commit_ring_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_commit_ring_ctrl;

    logic        clk;
    logic        reset;
    logic [2:0]  alloc_count;
    logic        alloc_ack;
    logic [4:0]  alloc_base;
    logic [2:0]  retire_count;
    logic        flush_valid;
    logic [4:0]  flush_index;
    logic [4:0]  commit_head;
    logic [4:0]  commit_tail;
    logic [31:0] commit_valid;
    logic [31:0] commit_valid_rot;
    logic [5:0]  free_count;
    logic        retire_err;

    int n_checks;
    int n_fail;

    commit_ring_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .alloc_count      (alloc_count),
        .alloc_ack        (alloc_ack),
        .alloc_base       (alloc_base),
        .retire_count     (retire_count),
        .flush_valid      (flush_valid),
        .flush_index      (flush_index),
        .commit_head      (commit_head),
        .commit_tail      (commit_tail),
        .commit_valid     (commit_valid),
        .commit_valid_rot (commit_valid_rot),
        .free_count       (free_count),
        .retire_err       (retire_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_count  = 3'd0;
        retire_count = 3'd0;
        flush_valid  = 1'b0;
        flush_index  = 5'd0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (commit_head !== 5'd0 || commit_tail !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_ptrs head=%0d tail=%0d required 0/0", commit_head, commit_tail);
        end
        n_checks++;
        if (free_count !== 6'd32 || commit_valid !== 32'h0 || commit_valid_rot !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state free=%0d valid=%h rot=%h required 32/0/0",
                     free_count, commit_valid, commit_valid_rot);
        end
        n_checks++;
        if (retire_err !== 1'b0 || alloc_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags err=%b ack=%b required 0/0", retire_err, alloc_ack);
        end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 8; k++) begin
            alloc_count = 3'd4;
            #1;
            n_checks++;
            if (alloc_ack !== 1'b1 || alloc_base !== 5'(4 * k)) begin
                n_fail++;
                $display("FAIL fill_ack[%0d] ack=%b base=%0d required 1/%0d", k, alloc_ack, alloc_base, 4 * k);
            end
            tick();
        end
        #1;
        n_checks++;
        if (alloc_ack !== 1'b0 || free_count !== 6'd0) begin
            n_fail++;
            $display("FAIL fill_full ack=%b free=%0d required 0/0", alloc_ack, free_count);
        end
        n_checks++;
        if (commit_valid !== 32'hFFFF_FFFF || commit_valid_rot !== 32'hFFFF_FFFF || commit_tail !== 5'd0) begin
            n_fail++;
            $display("FAIL fill_masks valid=%h rot=%h tail=%0d required ffffffff/ffffffff/0",
                     commit_valid, commit_valid_rot, commit_tail);
        end
    endtask

    task automatic test_full_retire_alloc();
        alloc_count  = 3'd4;
        retire_count = 3'd4;
        #1;
        n_checks++;
        if (alloc_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL full_retire_ack ack=%b required 0", alloc_ack);
        end
        tick();
        retire_count = 3'd0;
        #1;
        n_checks++;
        if (commit_head !== 5'd4 || free_count !== 6'd4) begin
            n_fail++;
            $display("FAIL full_retire_state head=%0d free=%0d required 4/4", commit_head, free_count);
        end
        n_checks++;
        if (commit_valid !== 32'hFFFF_FFF0 || commit_valid_rot !== 32'h0FFF_FFFF) begin
            n_fail++;
            $display("FAIL full_retire_masks valid=%h rot=%h required fffffff0/0fffffff",
                     commit_valid, commit_valid_rot);
        end
        n_checks++;
        if (alloc_ack !== 1'b1 || alloc_base !== 5'd0) begin
            n_fail++;
            $display("FAIL full_retire_realloc ack=%b base=%0d required 1/0", alloc_ack, alloc_base);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (free_count !== 6'd0 || commit_tail !== 5'd4) begin
            n_fail++;
            $display("FAIL full_retire_refill free=%0d tail=%0d required 0/4", free_count, commit_tail);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        alloc_count = 3'd4;
        tick();
        retire_count = 3'd4;
        for (int k = 0; k < 6; k++) tick();
        alloc_count = 3'd0;
        tick();
        retire_count = 3'd0;
        #1;
        n_checks++;
        if (commit_head !== 5'd28 || commit_tail !== 5'd28 || free_count !== 6'd32) begin
            n_fail++;
            $display("FAIL wrap_setup head=%0d tail=%0d free=%0d required 28/28/32",
                     commit_head, commit_tail, free_count);
        end
        alloc_count = 3'd4;
        #1;
        n_checks++;
        if (alloc_ack !== 1'b1 || alloc_base !== 5'd28) begin
            n_fail++;
            $display("FAIL wrap_base0 ack=%b base=%0d required 1/28", alloc_ack, alloc_base);
        end
        tick();
        n_checks++;
        if (alloc_ack !== 1'b1 || alloc_base !== 5'd0) begin
            n_fail++;
            $display("FAIL wrap_base1 ack=%b base=%0d required 1/0", alloc_ack, alloc_base);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (commit_valid !== 32'hF000_000F || commit_valid_rot !== 32'h0000_00FF) begin
            n_fail++;
            $display("FAIL wrap_masks valid=%h rot=%h required f000000f/000000ff",
                     commit_valid, commit_valid_rot);
        end
        n_checks++;
        if (commit_head !== 5'd28 || commit_tail !== 5'd4 || free_count !== 6'd24) begin
            n_fail++;
            $display("FAIL wrap_ptrs head=%0d tail=%0d free=%0d required 28/4/24",
                     commit_head, commit_tail, free_count);
        end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_count = 3'd4;
        for (int k = 0; k < 3; k++) tick();
        alloc_count  = 3'd0;
        retire_count = 3'd2;
        tick();
        retire_count = 3'd0;
        #1;
        n_checks++;
        if (commit_head !== 5'd2 || commit_tail !== 5'd12 || free_count !== 6'd22) begin
            n_fail++;
            $display("FAIL flush_setup head=%0d tail=%0d free=%0d required 2/12/22",
                     commit_head, commit_tail, free_count);
        end
        flush_valid = 1'b1;
        flush_index = 5'd6;
        alloc_count = 3'd3;
        #1;
        n_checks++;
        if (alloc_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ack ack=%b required 0", alloc_ack);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (commit_tail !== 5'd6 || free_count !== 6'd28 || commit_head !== 5'd2) begin
            n_fail++;
            $display("FAIL flush_ptrs head=%0d tail=%0d free=%0d required 2/6/28",
                     commit_head, commit_tail, free_count);
        end
        n_checks++;
        if (commit_valid !== 32'h0000_003C || commit_valid_rot !== 32'h0000_000F) begin
            n_fail++;
            $display("FAIL flush_masks valid=%h rot=%h required 0000003c/0000000f",
                     commit_valid, commit_valid_rot);
        end
    endtask

    task automatic test_retire_err();
        do_reset();
        alloc_count = 3'd2;
        tick();
        alloc_count  = 3'd0;
        retire_count = 3'd3;
        tick();
        retire_count = 3'd0;
        #1;
        n_checks++;
        if (commit_head !== 5'd2 || free_count !== 6'd32 || retire_err !== 1'b1) begin
            n_fail++;
            $display("FAIL retire_err_set head=%0d free=%0d err=%b required 2/32/1",
                     commit_head, free_count, retire_err);
        end
        tick();
        tick();
        n_checks++;
        if (retire_err !== 1'b1) begin
            n_fail++;
            $display("FAIL retire_err_sticky err=%b required 1", retire_err);
        end
        // reset wins over a same-cycle alloc
        reset       = 1'b1;
        alloc_count = 3'd4;
        tick();
        reset       = 1'b0;
        alloc_count = 3'd0;
        #1;
        n_checks++;
        if (retire_err !== 1'b0 || commit_head !== 5'd0 || commit_tail !== 5'd0 || free_count !== 6'd32) begin
            n_fail++;
            $display("FAIL retire_err_clear err=%b head=%0d tail=%0d free=%0d required 0/0/0/32",
                     retire_err, commit_head, commit_tail, free_count);
        end
    endtask

    task automatic test_flush_all();
        do_reset();
        alloc_count = 3'd4;
        tick();
        alloc_count  = 3'd0;
        retire_count = 3'd1;
        flush_valid  = 1'b1;
        flush_index  = 5'd1;
        tick();
        idle();
        #1;
        n_checks++;
        if (commit_valid !== 32'h0 || commit_valid_rot !== 32'h0 || free_count !== 6'd32) begin
            n_fail++;
            $display("FAIL flush_all_state valid=%h rot=%h free=%0d required 0/0/32",
                     commit_valid, commit_valid_rot, free_count);
        end
        n_checks++;
        if (commit_head !== 5'd1 || commit_tail !== 5'd1) begin
            n_fail++;
            $display("FAIL flush_all_ptrs head=%0d tail=%0d required 1/1", commit_head, commit_tail);
        end
        alloc_count = 3'd1;
        #1;
        n_checks++;
        if (alloc_ack !== 1'b1 || alloc_base !== 5'd1) begin
            n_fail++;
            $display("FAIL flush_all_realloc ack=%b base=%0d required 1/1", alloc_ack, alloc_base);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (commit_valid !== 32'h0000_0002 || commit_valid_rot !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL flush_all_one valid=%h rot=%h required 00000002/00000001",
                     commit_valid, commit_valid_rot);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle();
        test_reset();
        test_fill();
        test_full_retire_alloc();
        test_wrap();
        test_flush();
        test_retire_err();
        test_flush_all();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
